multicycle_control_unit: RTL and testbench

- Multi-cycle successor to the single-cycle opcode decoder.
- Sequences every instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states and emits per-state write strobes.
- Adds a parametrised memory-latency wait, an input handshake for the `in` instruction, a resumable halt and illegal-opcode detection.
- Sits between the instruction register and the datapath (PC, register file, ALU, data memory, output port).

---
 rtl/multicycle_control_unit_pkg.sv | 85 ++++++++
 rtl/control_opcode_decode.sv | 44 ++++
 rtl/multicycle_control_unit.sv | 162 ++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states,
// ALU operations, writeback sources and the decoded control bundle.
package multicycle_control_unit_pkg;

  localparam int unsigned OPC_W = 5;
  localparam int unsigned ALU_W = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned WB_W  = 2;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'd0;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'd1;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'd2;
  localparam logic [OPC_W-1:0] OP_SUBI = 5'd3;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'd4;
  localparam logic [OPC_W-1:0] OP_HALT = 5'd5;
  localparam logic [OPC_W-1:0] OP_JUMP = 5'd6;
  localparam logic [OPC_W-1:0] OP_BEQ  = 5'd7;
  localparam logic [OPC_W-1:0] OP_BNE  = 5'd8;
  localparam logic [OPC_W-1:0] OP_SLT  = 5'd9;
  localparam logic [OPC_W-1:0] OP_LW   = 5'd10;
  localparam logic [OPC_W-1:0] OP_SW   = 5'd11;
  localparam logic [OPC_W-1:0] OP_IN   = 5'd12;
  localparam logic [OPC_W-1:0] OP_OUT  = 5'd13;
  localparam logic [OPC_W-1:0] OP_LI   = 5'd14;
  localparam logic [OPC_W-1:0] OP_AND  = 5'd15;
  localparam logic [OPC_W-1:0] OP_ANDI = 5'd16;
  localparam logic [OPC_W-1:0] OP_OR   = 5'd17;
  localparam logic [OPC_W-1:0] OP_ORI  = 5'd18;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'd19;
  localparam logic [OPC_W-1:0] OP_XOR  = 5'd20;
  localparam logic [OPC_W-1:0] OP_XORI = 5'd21;
  localparam logic [OPC_W-1:0] OP_SLL  = 5'd22;
  localparam logic [OPC_W-1:0] OP_SRL  = 5'd23;

  localparam logic [ALU_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_W-1:0] ALU_SLT = 4'd2;
  localparam logic [ALU_W-1:0] ALU_NOT = 4'd3;
  localparam logic [ALU_W-1:0] ALU_AND = 4'd4;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'd5;
  localparam logic [ALU_W-1:0] ALU_XOR = 4'd6;
  localparam logic [ALU_W-1:0] ALU_SLL = 4'd7;
  localparam logic [ALU_W-1:0] ALU_SRL = 4'd8;
  localparam logic [ALU_W-1:0] ALU_LI  = 4'd9;

  localparam logic [WB_W-1:0] WB_ALU = 2'd0;
  localparam logic [WB_W-1:0] WB_MEM = 2'd1;
  localparam logic [WB_W-1:0] WB_IN  = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_WAIT_IN   = 3'd5,
    ST_HALTED    = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BEQ, CLS_BNE, CLS_JUMP,
    CLS_IN, CLS_OUT, CLS_HALT, CLS_NOP, CLS_ILLEGAL
  } instr_class_t;

  typedef struct packed {
    instr_class_t     cls;
    logic [ALU_W-1:0] aluop;
    logic             alu_src;
    logic             reg_dst;
    logic [WB_W-1:0]  wb_sel;
  } ctrl_t;

  function automatic ctrl_t mk_ctrl(input instr_class_t cls, input logic [ALU_W-1:0] aluop,
                                    input logic alu_src, input logic reg_dst,
                                    input logic [WB_W-1:0] wb_sel);
    ctrl_t c;
    c.cls     = cls;
    c.aluop   = aluop;
    c.alu_src = alu_src;
    c.reg_dst = reg_dst;
    c.wb_sel  = wb_sel;
    return c;
  endfunction

endpackage

// File: rtl/control_opcode_decode.sv
// Static opcode map: instruction class, ALU op and datapath selectors.
// Immediate forms, lw and in write the rt field; everything else writes rd.
module control_opcode_decode
  import multicycle_control_unit_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  input  logic             upper_set,
  output ctrl_t            ctrl
);

  always_comb begin
    ctrl = mk_ctrl(CLS_ILLEGAL, ALU_ADD, 1'b0, 1'b0, WB_ALU);
    if (!upper_set) begin
      case (opcode)
        OP_ADD:  ctrl = mk_ctrl(CLS_ALU,   ALU_ADD, 1'b0, 1'b0, WB_ALU);
        OP_ADDI: ctrl = mk_ctrl(CLS_ALU,   ALU_ADD, 1'b1, 1'b1, WB_ALU);
        OP_SUB:  ctrl = mk_ctrl(CLS_ALU,   ALU_SUB, 1'b0, 1'b0, WB_ALU);
        OP_SUBI: ctrl = mk_ctrl(CLS_ALU,   ALU_SUB, 1'b1, 1'b1, WB_ALU);
        OP_NOP:  ctrl = mk_ctrl(CLS_NOP,   ALU_ADD, 1'b0, 1'b0, WB_ALU);
        OP_HALT: ctrl = mk_ctrl(CLS_HALT,  ALU_ADD, 1'b0, 1'b0, WB_ALU);
        OP_JUMP: ctrl = mk_ctrl(CLS_JUMP,  ALU_ADD, 1'b0, 1'b0, WB_ALU);
        OP_BEQ:  ctrl = mk_ctrl(CLS_BEQ,   ALU_SUB, 1'b0, 1'b0, WB_ALU);
        OP_BNE:  ctrl = mk_ctrl(CLS_BNE,   ALU_SUB, 1'b0, 1'b0, WB_ALU);
        OP_SLT:  ctrl = mk_ctrl(CLS_ALU,   ALU_SLT, 1'b0, 1'b0, WB_ALU);
        OP_LW:   ctrl = mk_ctrl(CLS_LOAD,  ALU_ADD, 1'b1, 1'b1, WB_MEM);
        OP_SW:   ctrl = mk_ctrl(CLS_STORE, ALU_ADD, 1'b1, 1'b0, WB_ALU);
        OP_IN:   ctrl = mk_ctrl(CLS_IN,    ALU_ADD, 1'b0, 1'b1, WB_IN);
        OP_OUT:  ctrl = mk_ctrl(CLS_OUT,   ALU_ADD, 1'b0, 1'b0, WB_ALU);
        OP_LI:   ctrl = mk_ctrl(CLS_ALU,   ALU_LI,  1'b1, 1'b1, WB_ALU);
        OP_AND:  ctrl = mk_ctrl(CLS_ALU,   ALU_AND, 1'b0, 1'b0, WB_ALU);
        OP_ANDI: ctrl = mk_ctrl(CLS_ALU,   ALU_AND, 1'b1, 1'b1, WB_ALU);
        OP_OR:   ctrl = mk_ctrl(CLS_ALU,   ALU_OR,  1'b0, 1'b0, WB_ALU);
        OP_ORI:  ctrl = mk_ctrl(CLS_ALU,   ALU_OR,  1'b1, 1'b1, WB_ALU);
        OP_NOT:  ctrl = mk_ctrl(CLS_ALU,   ALU_NOT, 1'b0, 1'b0, WB_ALU);
        OP_XOR:  ctrl = mk_ctrl(CLS_ALU,   ALU_XOR, 1'b0, 1'b0, WB_ALU);
        OP_XORI: ctrl = mk_ctrl(CLS_ALU,   ALU_XOR, 1'b1, 1'b1, WB_ALU);
        OP_SLL:  ctrl = mk_ctrl(CLS_ALU,   ALU_SLL, 1'b0, 1'b0, WB_ALU);
        OP_SRL:  ctrl = mk_ctrl(CLS_ALU,   ALU_SRL, 1'b0, 1'b0, WB_ALU);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle instruction sequencer: walks each instruction through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and emits per-state datapath strobes.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH = 5,
  parameter int unsigned ALUOP_WIDTH  = 4,
  parameter int unsigned MEM_LATENCY  = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    zero_alu,
  input  logic                    in_valid,
  input  logic                    resume,
  output logic                    pc_write_enabled,
  output logic                    instruction_write_enabled,
  output logic                    pc_selector,
  output logic                    register_destiny_selector,
  output logic                    register_write_enabled,
  output logic                    alu_input2_selector,
  output logic [ALUOP_WIDTH-1:0]  aluop_selector,
  output logic                    memory_write_enabled,
  output logic                    output_write_enabled,
  output logic [1:0]              alu_mem_output_selector,
  output logic                    in_ack,
  output logic                    halted,
  output logic                    illegal_opcode,
  output logic [2:0]              state
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  state_t           state_q, state_d;
  logic [OPC_W-1:0] opcode_q, opcode_lo, dec_opcode;
  logic             upper_set, dec_upper;
  logic [CNT_W-1:0] cnt_q;
  ctrl_t            ctrl;

  assign opcode_lo = OPC_W'(opcode);
  assign upper_set = (opcode >> OPC_W) != '0;

  // DECODE looks at the live opcode; later states use the latched copy.
  assign dec_opcode = (state_q == ST_DECODE) ? opcode_lo : opcode_q;
  assign dec_upper  = (state_q == ST_DECODE) && upper_set;

  control_opcode_decode u_decode (
    .opcode    (dec_opcode),
    .upper_set (dec_upper),
    .ctrl      (ctrl)
  );

  assign state = state_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      opcode_q <= OP_NOP;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) begin
        opcode_q <= (ctrl.cls == CLS_ILLEGAL) ? OP_NOP : opcode_lo;
      end
      if (state_q == ST_EXECUTE) begin
        cnt_q <= CNT_LOAD;
      end else if (state_q == ST_MEMORY && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Reset gates every output so FETCH strobes only appear after release.
  always_comb begin
    state_d                   = state_q;
    pc_write_enabled          = 1'b0;
    instruction_write_enabled = 1'b0;
    pc_selector               = 1'b0;
    register_destiny_selector = 1'b0;
    register_write_enabled    = 1'b0;
    alu_input2_selector       = 1'b0;
    aluop_selector            = '0;
    memory_write_enabled      = 1'b0;
    output_write_enabled      = 1'b0;
    alu_mem_output_selector   = '0;
    in_ack                    = 1'b0;
    halted                    = 1'b0;
    illegal_opcode            = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          instruction_write_enabled = 1'b1;
          pc_write_enabled          = 1'b1;
          state_d                   = ST_DECODE;
        end
        ST_DECODE: begin
          case (ctrl.cls)
            CLS_NOP:     state_d = ST_FETCH;
            CLS_HALT:    state_d = ST_HALTED;
            CLS_IN:      state_d = ST_WAIT_IN;
            CLS_ILLEGAL: begin
              illegal_opcode = 1'b1;
              state_d        = ST_FETCH;
            end
            default:     state_d = ST_EXECUTE;
          endcase
        end
        ST_EXECUTE: begin
          aluop_selector      = ALUOP_WIDTH'(ctrl.aluop);
          alu_input2_selector = ctrl.alu_src;
          state_d             = ST_FETCH;
          case (ctrl.cls)
            CLS_ALU:   state_d = ST_WRITEBACK;
            CLS_LOAD,
            CLS_STORE: state_d = ST_MEMORY;
            CLS_JUMP: begin
              pc_write_enabled = 1'b1;
              pc_selector      = 1'b1;
            end
            CLS_BEQ: begin
              pc_write_enabled = zero_alu;
              pc_selector      = zero_alu;
            end
            CLS_BNE: begin
              pc_write_enabled = !zero_alu;
              pc_selector      = !zero_alu;
            end
            CLS_OUT:   output_write_enabled = 1'b1;
            default: ;
          endcase
        end
        ST_MEMORY: begin
          // Counter was loaded on entry, so CNT_LOAD marks the first cycle.
          memory_write_enabled = (ctrl.cls == CLS_STORE) && (cnt_q == CNT_LOAD);
          if (cnt_q == '0) begin
            state_d = (ctrl.cls == CLS_STORE) ? ST_FETCH : ST_WRITEBACK;
          end
        end
        ST_WRITEBACK: begin
          register_write_enabled    = 1'b1;
          register_destiny_selector = ctrl.reg_dst;
          alu_mem_output_selector   = ctrl.wb_sel;
          state_d                   = ST_FETCH;
        end
        ST_WAIT_IN: begin
          if (in_valid) begin
            in_ack  = 1'b1;
            state_d = ST_WRITEBACK;
          end
        end
        ST_HALTED: begin
          halted = 1'b1;
          if (resume) begin
            state_d = ST_FETCH;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: expected per-cycle control words are queued per
// instruction and compared against the DUT on each falling edge.
module tb_multicycle_control_unit;

  localparam int unsigned MEM_LAT = 3;

  typedef struct packed {
    logic [2:0] st;
    logic       ir_we;
    logic       pc_we;
    logic       pc_sel;
    logic       reg_we;
    logic       reg_dst;
    logic       alu_src;
    logic [3:0] aluop;
    logic       mem_we;
    logic       out_we;
    logic [1:0] wb;
    logic       in_ack;
    logic       halted;
    logic       illegal;
  } obs_t;

  // {opcode, aluop, alu_src, reg_dst} for the ALU-class opcodes other than add
  localparam logic [10:0] ALU_TAB [14] = '{
    {5'd1,  4'd0, 1'b1, 1'b1}, {5'd2,  4'd1, 1'b0, 1'b0}, {5'd3,  4'd1, 1'b1, 1'b1},
    {5'd9,  4'd2, 1'b0, 1'b0}, {5'd14, 4'd9, 1'b1, 1'b1}, {5'd15, 4'd4, 1'b0, 1'b0},
    {5'd16, 4'd4, 1'b1, 1'b1}, {5'd17, 4'd5, 1'b0, 1'b0}, {5'd18, 4'd5, 1'b1, 1'b1},
    {5'd19, 4'd3, 1'b0, 1'b0}, {5'd20, 4'd6, 1'b0, 1'b0}, {5'd21, 4'd6, 1'b1, 1'b1},
    {5'd22, 4'd7, 1'b0, 1'b0}, {5'd23, 4'd8, 1'b0, 1'b0}
  };

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] opcode;
  logic       zero_alu, in_valid, resume;
  logic       pc_write_enabled, instruction_write_enabled, pc_selector;
  logic       register_destiny_selector, register_write_enabled, alu_input2_selector;
  logic [3:0] aluop_selector;
  logic       memory_write_enabled, output_write_enabled;
  logic [1:0] alu_mem_output_selector;
  logic       in_ack, halted, illegal_opcode;
  logic [2:0] state;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  multicycle_control_unit #(
    .OPCODE_WIDTH (5),
    .ALUOP_WIDTH  (4),
    .MEM_LATENCY  (MEM_LAT)
  ) dut (
    .clock                     (clock),
    .reset                     (reset),
    .opcode                    (opcode),
    .zero_alu                  (zero_alu),
    .in_valid                  (in_valid),
    .resume                    (resume),
    .pc_write_enabled          (pc_write_enabled),
    .instruction_write_enabled (instruction_write_enabled),
    .pc_selector               (pc_selector),
    .register_destiny_selector (register_destiny_selector),
    .register_write_enabled    (register_write_enabled),
    .alu_input2_selector       (alu_input2_selector),
    .aluop_selector            (aluop_selector),
    .memory_write_enabled      (memory_write_enabled),
    .output_write_enabled      (output_write_enabled),
    .alu_mem_output_selector   (alu_mem_output_selector),
    .in_ack                    (in_ack),
    .halted                    (halted),
    .illegal_opcode            (illegal_opcode),
    .state                     (state)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  function automatic obs_t sample();
    obs_t r;
    r.st      = state;
    r.ir_we   = instruction_write_enabled;
    r.pc_we   = pc_write_enabled;
    r.pc_sel  = pc_selector;
    r.reg_we  = register_write_enabled;
    r.reg_dst = register_destiny_selector;
    r.alu_src = alu_input2_selector;
    r.aluop   = aluop_selector;
    r.mem_we  = memory_write_enabled;
    r.out_we  = output_write_enabled;
    r.wb      = alu_mem_output_selector;
    r.in_ack  = in_ack;
    r.halted  = halted;
    r.illegal = illegal_opcode;
    return r;
  endfunction

  function automatic obs_t f_fetch();
    obs_t r = '0;
    r.st = 3'd0; r.ir_we = 1'b1; r.pc_we = 1'b1;
    return r;
  endfunction

  function automatic obs_t f_decode(input logic ill);
    obs_t r = '0;
    r.st = 3'd1; r.illegal = ill;
    return r;
  endfunction

  function automatic obs_t f_exec(input logic [3:0] aluop, input logic src,
                                  input logic pcw, input logic pcs, input logic outw);
    obs_t r = '0;
    r.st = 3'd2; r.aluop = aluop; r.alu_src = src;
    r.pc_we = pcw; r.pc_sel = pcs; r.out_we = outw;
    return r;
  endfunction

  function automatic obs_t f_mem(input logic mw);
    obs_t r = '0;
    r.st = 3'd3; r.mem_we = mw;
    return r;
  endfunction

  function automatic obs_t f_wb(input logic dst, input logic [1:0] wb);
    obs_t r = '0;
    r.st = 3'd4; r.reg_we = 1'b1; r.reg_dst = dst; r.wb = wb;
    return r;
  endfunction

  function automatic obs_t f_wait(input logic ack);
    obs_t r = '0;
    r.st = 3'd5; r.in_ack = ack;
    return r;
  endfunction

  function automatic obs_t f_halt();
    obs_t r = '0;
    r.st = 3'd6; r.halted = 1'b1;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Pop one expectation per cycle; entered and left just after a rising edge.
  task automatic drain(input string tag);
    int i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clock);
      check($sformatf("%s c%0d", tag, i), 32'(sample()), 32'(exp_q.pop_front()));
      @(posedge clock);
      #1;
      i++;
    end
  endtask

  initial begin
    logic [10:0] e;
    logic        taken;
    opcode   = 5'd4;
    zero_alu = 1'b0;
    in_valid = 1'b0;
    resume   = 1'b0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset idle", 32'(sample()), 32'(obs_t'('0)));
    @(posedge clock);
    #1;
    reset = 1'b0;

    opcode = 5'd0;
    exp_q.push_back(f_fetch());
    exp_q.push_back(f_decode(1'b0));
    exp_q.push_back(f_exec(4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(f_wb(1'b0, 2'd0));
    drain("add");

    for (int i = 0; i < 14; i++) begin
      e = ALU_TAB[i];
      opcode = e[10:6];
      exp_q.push_back(f_fetch());
      exp_q.push_back(f_decode(1'b0));
      exp_q.push_back(f_exec(e[5:2], e[1], 1'b0, 1'b0, 1'b0));
      exp_q.push_back(f_wb(e[0], 2'd0));
      drain($sformatf("alu op%0d", e[10:6]));
    end

    opcode = 5'd10;
    exp_q.push_back(f_fetch());
    exp_q.push_back(f_decode(1'b0));
    exp_q.push_back(f_exec(4'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < MEM_LAT; i++) exp_q.push_back(f_mem(1'b0));
    exp_q.push_back(f_wb(1'b1, 2'd1));
    drain("lw");

    opcode = 5'd11;
    exp_q.push_back(f_fetch());
    exp_q.push_back(f_decode(1'b0));
    exp_q.push_back(f_exec(4'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(f_mem(1'b1));
    for (int i = 1; i < MEM_LAT; i++) exp_q.push_back(f_mem(1'b0));
    drain("sw");

    // beq/bne with both zero flag values
    for (int i = 0; i < 4; i++) begin
      opcode   = (i < 2) ? 5'd7 : 5'd8;
      zero_alu = i[0];
      taken    = (i < 2) ? i[0] : !i[0];
      exp_q.push_back(f_fetch());
      exp_q.push_back(f_decode(1'b0));
      exp_q.push_back(f_exec(4'd1, 1'b0, taken, taken, 1'b0));
      drain($sformatf("%s z%0d", (i < 2) ? "beq" : "bne", i[0]));
    end
    zero_alu = 1'b0;

    opcode = 5'd6;
    exp_q.push_back(f_fetch());
    exp_q.push_back(f_decode(1'b0));
    exp_q.push_back(f_exec(4'd0, 1'b0, 1'b1, 1'b1, 1'b0));
    drain("jump");

    opcode = 5'd13;
    exp_q.push_back(f_fetch());
    exp_q.push_back(f_decode(1'b0));
    exp_q.push_back(f_exec(4'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    drain("out");

    opcode = 5'd12;
    exp_q.push_back(f_fetch());
    exp_q.push_back(f_decode(1'b0));
    drain("in pre");
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(f_wait(1'b0));
      drain("in wait");
    end
    in_valid = 1'b1;
    exp_q.push_back(f_wait(1'b1));
    drain("in ack");
    in_valid = 1'b0;
    exp_q.push_back(f_wb(1'b1, 2'd2));
    drain("in wb");

    opcode = 5'd5;
    exp_q.push_back(f_fetch());
    exp_q.push_back(f_decode(1'b0));
    drain("halt pre");
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      exp_q.push_back(f_halt());
      drain("halted");
    end
    in_valid = 1'b0;
    resume   = 1'b1;
    exp_q.push_back(f_halt());
    drain("halt resume");
    resume = 1'b0;

    opcode = 5'd31;
    exp_q.push_back(f_fetch());
    exp_q.push_back(f_decode(1'b1));
    drain("illegal 31");
    opcode = 5'd24;
    exp_q.push_back(f_fetch());
    exp_q.push_back(f_decode(1'b1));
    drain("illegal 24");
    opcode = 5'd4;
    exp_q.push_back(f_fetch());
    exp_q.push_back(f_decode(1'b0));
    drain("nop");

    opcode = 5'd10;
    exp_q.push_back(f_fetch());
    exp_q.push_back(f_decode(1'b0));
    exp_q.push_back(f_exec(4'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(f_mem(1'b0));
    drain("lw pre-reset");
    reset = 1'b1;
    #1;
    check("reset mid-mem async", 32'(sample()), 32'(obs_t'('0)));
    @(negedge clock);
    check("reset mid-mem held", 32'(sample()), 32'(obs_t'('0)));
    @(posedge clock);
    #1;
    reset = 1'b0;

    opcode = 5'd5;
    exp_q.push_back(f_fetch());
    exp_q.push_back(f_decode(1'b0));
    exp_q.push_back(f_halt());
    drain("halt before reset");
    resume = 1'b1;
    reset  = 1'b1;
    #1;
    check("reset beats resume", 32'(sample()), 32'(obs_t'('0)));
    @(posedge clock);
    #1;
    reset  = 1'b0;
    resume = 1'b0;
    opcode = 5'd4;
    exp_q.push_back(f_fetch());
    exp_q.push_back(f_decode(1'b0));
    exp_q.push_back(f_fetch());
    drain("after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
